// File: rtl/sn_pkg.sv
// Shared constants and types for the stochastic-number stream encoder/decoder.
package sn_pkg;

  localparam int unsigned LfsrW     = 31;
  localparam int unsigned LfsrTapA  = 27;
  localparam int unsigned LfsrTapB  = 30;
  localparam logic [LfsrW-1:0] LfsrSeed = 31'd1;

  localparam int unsigned DefProbW   = 8;
  localparam int unsigned DefLenLog2 = 7;

  typedef enum logic {
    StIdle,
    StRun
  } sn_state_e;

  // One Fibonacci step: shift left, feedback enters at bit 0.
  function automatic logic [LfsrW-1:0] lfsr_next(input logic [LfsrW-1:0] s);
    return {s[LfsrW-2:0], s[LfsrTapA] ^ s[LfsrTapB]};
  endfunction

endpackage

// File: rtl/sn_lfsr31.sv
// 31-bit Fibonacci LFSR with advance enable; shared by encoder and decoder sides.
module sn_lfsr31
  import sn_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,   // active-high asynchronous reset
  input  logic             adv_i,
  output logic [LfsrW-1:0] state_o
);

  logic [LfsrW-1:0] lfsr_q;

  // Step the register only when a beat is consumed.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      lfsr_q <= LfsrSeed;
    end else if (adv_i) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/sn_stream_encoder.sv
// Binary probability to stochastic bit-stream encoder, one frame per accepted word.
// Optional feature: define SN_ONES_COUNT_EN to add a per-frame ones tally (ones_cnt/cnt_valid).
module sn_stream_encoder
  import sn_pkg::*;
#(
  parameter int unsigned PROB_W   = DefProbW,
  parameter int unsigned LEN_LOG2 = DefLenLog2
) (
  input  logic              clk,
  input  logic              rst_n,      // active-high asynchronous reset
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROB_W-1:0] in_prob,
  input  logic              sn_ready,
  output logic              sn_valid,
  output logic              sn_bit,
  output logic              sn_first,
`ifdef SN_ONES_COUNT_EN
  output logic              sn_last,
  output logic [LEN_LOG2:0] ones_cnt,
  output logic              cnt_valid
`else
  output logic              sn_last
`endif
);

  localparam logic [LEN_LOG2-1:0] LastBeat = '1;

  sn_state_e           state_q;
  logic [PROB_W-1:0]   prob_q;
  logic [LEN_LOG2-1:0] cnt_q;
  logic [LfsrW-1:0]    lfsr;
  logic                run;
  logic                fire;
  logic                accept;

  sn_lfsr31 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .adv_i   (fire),
    .state_o (lfsr)
  );

  // Only the low compare slice of the LFSR feeds the comparator.
  logic unused_lfsr_hi;
  assign unused_lfsr_hi = ^lfsr[LfsrW-1:PROB_W];

  // Stream outputs are decoded from registered state, so they hold while stalled.
  always_comb begin
    run      = (state_q == StRun);
    sn_valid = run;
    sn_bit   = run && (lfsr[PROB_W-1:0] < prob_q);
    sn_first = run && (cnt_q == '0);
    sn_last  = run && (cnt_q == LastBeat);
    // Accept the next word on the completing last beat for gap-free frames.
    in_ready = !run || (sn_last && sn_ready);
    fire     = sn_valid && sn_ready;
    accept   = in_valid && in_ready;
  end

  // Frame FSM: capture probability, count beats, chain or return to idle.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= StIdle;
      prob_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            prob_q  <= in_prob;
            cnt_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (fire) begin
            if (cnt_q == LastBeat) begin
              cnt_q <= '0;
              if (accept) begin
                prob_q <= in_prob;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SN_ONES_COUNT_EN
  logic [LEN_LOG2:0] tally_q;
  logic [LEN_LOG2:0] ones_cnt_q;
  logic              cnt_valid_q;
  logic [LEN_LOG2:0] bit_ext;

  assign bit_ext = {{LEN_LOG2{1'b0}}, sn_bit};

  // Tally ones of completed beats; publish the total on the last beat.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tally_q     <= '0;
      ones_cnt_q  <= '0;
      cnt_valid_q <= 1'b0;
    end else begin
      cnt_valid_q <= 1'b0;
      if (fire) begin
        if (sn_last) begin
          ones_cnt_q  <= tally_q + bit_ext;
          cnt_valid_q <= 1'b1;
          tally_q     <= '0;
        end else begin
          tally_q <= tally_q + bit_ext;
        end
      end
    end
  end

  assign ones_cnt  = ones_cnt_q;
  assign cnt_valid = cnt_valid_q;
`endif

endmodule

// File: doc/sn_stream_encoder.md
SN_STREAM_ENCODER -- requirements
Module: sn_stream_encoder

Interface
REQ-001 SHALL have parameter PROB_W, default 8, width of binary probability input and LFSR compare slice.
REQ-002 SHALL have parameter LEN_LOG2, default 7, stream length 2^LEN_LOG2 (128) bits per frame.
REQ-003 SHALL have port clk  input  1  the single clock; all state on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-high despite the name.
REQ-005 SHALL have port in_valid  input  1  probability word offered.
REQ-006 SHALL have port in_ready  output  1  encoder accepts a word this cycle.
REQ-007 SHALL have port in_prob  input  PROB_W  unsigned probability, P = in_prob / 2^PROB_W.
REQ-008 SHALL have port sn_ready  input  1  downstream consumes the current bit.
REQ-009 SHALL have port sn_valid  output  1  sn_bit is a valid stream beat.
REQ-010 SHALL have port sn_bit  output  1  stochastic stream bit.
REQ-011 SHALL have port sn_first  output  1  current beat is beat 0 of the frame.
REQ-012 SHALL have port sn_last  output  1  current beat is beat 2^LEN_LOG2-1 of the frame.

Function
REQ-013 SHALL implement a two-state FSM, IDLE and RUN.
REQ-014 In IDLE: in_ready=1, sn_valid=0; on in_valid&&in_ready, SHALL capture in_prob into prob_q, clear beat counter, enter RUN next cycle.
REQ-015 In RUN: sn_valid=1; sn_bit = (lfsr[PROB_W-1:0] < prob_q), unsigned compare.
REQ-016 A beat SHALL complete only on sn_valid&&sn_ready; on completion the beat counter increments and the LFSR advances once.
REQ-017 With sn_ready=0, sn_bit, sn_first, sn_last, counter and LFSR SHALL hold.
REQ-018 LFSR SHALL be 31-bit Fibonacci, new bit[0] = bit[27]^bit[30], shift left; it never resets between frames.
REQ-019 sn_first=1 when RUN and counter=0; sn_last=1 when RUN and counter=2^LEN_LOG2-1.
REQ-020 in_ready SHALL also be 1 in RUN when sn_last&&sn_ready (back-to-back frames); accepted word starts next frame with counter=0, no idle gap.
REQ-021 After the last beat with no word accepted, SHALL return to IDLE.
REQ-022 in_valid in RUN outside the last completing beat SHALL be ignored; prob_q SHALL not change mid-frame.
REQ-023 prob_q=0 SHALL yield all-zero frame; prob_q=2^PROB_W-1 yields 1 only when slice < prob_q.
REQ-024 Counter SHALL wrap from 2^LEN_LOG2-1 to 0 only via frame completion.

Reset
REQ-025 On rst_n=1, asynchronously: state=IDLE, lfsr=31'd1, prob_q=0, counter=0.
REQ-026 Output values during/after reset: in_ready=1, sn_valid=0, sn_bit=0, sn_first=0, sn_last=0.
REQ-027 Reset mid-frame SHALL abort the frame; no further beats of it are emitted.

Configuration
REQ-028 With SN_ONES_COUNT_EN defined, SHALL add outputs ones_cnt [LEN_LOG2:0] and cnt_valid [1].
REQ-029 With SN_ONES_COUNT_EN: ones_cnt counts completed beats with sn_bit=1; on the completing sn_last beat, cnt_valid pulses 1 cycle with the final frame total (0..2^LEN_LOG2) held until next frame end; internal tally clears for next frame; reset value 0.
REQ-030 Without SN_ONES_COUNT_EN, those ports and logic SHALL not exist; all other behaviour identical.

Structure
REQ-031 Package sn_pkg SHALL hold: LFSR width 31, tap indices 27/30, seed 31'd1, FSM state typedef, default PROB_W/LEN_LOG2.
REQ-032 LFSR SHALL be sub-module sn_lfsr31 (clk, rst_n, advance enable, 31-bit state out), reusable by the decoder side.

Verification
REQ-033 Reset then in_prob=0, sn_ready=1 -> 128 beats, all sn_bit=0, sn_first at beat 0, sn_last at beat 127, then IDLE.
REQ-034 in_prob=128, sn_ready=1 -> sn_bit sequence and ones total match bit-exact model of seed-1 LFSR; cnt_valid total equals model.
REQ-035 sn_ready toggled every other cycle -> identical 128-bit sequence to REQ-034, frame takes ~256 cycles, outputs stable while stalled.
REQ-036 in_valid held with 64 then 192 -> in_ready on beat 127 of frame 1, frame 2 sn_first the next cycle, no gap; in_valid=1 mid-frame does not alter prob_q.
REQ-037 rst_n=1 at beat 50 -> sn_valid=0 immediately, lfsr=1; next frame reproduces REQ-034 sequence from start.
REQ-038 Both macro settings built -> non-count ports bit-identical across same stimulus.
